// File: rtl/axis_averager_pkg.sv
// Shared types and helpers for the coherent frame averager.
// Sign extension and arithmetic shift work on a 64-bit carrier; callers truncate to their width.
package axis_averager_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DRAIN = 2'd2
   } state_t;

   localparam int WORD_MAX   = 64;
   localparam int SKID_DEPTH = 2;

   function automatic bit widths_ok(input int axis_w, input int bram_w, input int log2_max);
      return (axis_w >= 1) && (bram_w <= WORD_MAX) && (bram_w >= axis_w + log2_max);
   endfunction

   // Sign-extend the low w bits of v to the full carrier width.
   function automatic logic [WORD_MAX-1:0] sext(input logic [WORD_MAX-1:0] v, input int w);
      logic signed [WORD_MAX-1:0] t;
      t = signed'(v << (WORD_MAX - w));
      return t >>> (WORD_MAX - w);
   endfunction

   // Treat the low w bits of v as signed and shift right arithmetically by sh.
   function automatic logic [WORD_MAX-1:0] asr(input logic [WORD_MAX-1:0] v, input int w, input int sh);
      logic signed [WORD_MAX-1:0] t;
      t = signed'(sext(v, w));
      return t >>> sh;
   endfunction

endpackage

// File: rtl/axis_averager_skid.sv
// Two-entry AXI-Stream output buffer for the drain path.
// credit counts the slots that are free once this cycle's pop (if any) retires.
module axis_averager_skid
   import axis_averager_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_last,
   output logic [1:0]            credit,
   output logic [DATA_WIDTH-1:0] m_tdata,
   output logic                  m_tvalid,
   input  logic                  m_tready,
   output logic                  m_tlast
);

   logic [DATA_WIDTH:0] entry_q [SKID_DEPTH];
   logic                rd_ptr;
   logic                wr_ptr;
   logic [1:0]          count;
   logic                pop;

   assign m_tvalid = (count != 2'd0);
   assign pop      = m_tvalid & m_tready;
   assign credit   = 2'(SKID_DEPTH) - count + {1'b0, pop};
   assign {m_tlast, m_tdata} = entry_q[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (in_valid) wr_ptr <= ~wr_ptr;
         if (pop)      rd_ptr <= ~rd_ptr;
         count <= count + {1'b0, in_valid} - {1'b0, pop};
      end
   end

   // NOTE: payload storage is deliberately not reset; validity is carried by count alone.
   always_ff @(posedge clk) begin
      if (in_valid) entry_q[wr_ptr] <= {in_last, in_data};
   end

endmodule

// File: rtl/axis_frame_averager.sv
// Coherent frame averager: accumulates 2^cfg_log2_avg frames in external BRAM,
// then streams the arithmetically shifted sums on M_AXIS with tlast.
module axis_frame_averager
   import axis_averager_pkg::*;
#(
   parameter int AXIS_TDATA_WIDTH = 16,
   parameter int BRAM_DATA_WIDTH  = 32,
   parameter int BRAM_ADDR_WIDTH  = 10,
   parameter int LOG2_AVG_MAX     = 8
) (
   input  logic                                aclk,
   input  logic                                areset,
   input  logic [BRAM_ADDR_WIDTH-1:0]          cfg_frame_len,
   input  logic [$clog2(LOG2_AVG_MAX+1)-1:0]   cfg_log2_avg,
   input  logic                                cfg_enable,
   input  logic [AXIS_TDATA_WIDTH-1:0]         S_AXIS_tdata,
   input  logic                                S_AXIS_tvalid,
   output logic                                S_AXIS_tready,
   output logic [BRAM_DATA_WIDTH-1:0]          M_AXIS_tdata,
   output logic                                M_AXIS_tvalid,
   input  logic                                M_AXIS_tready,
   output logic                                M_AXIS_tlast,
   output logic                                bram_porta_clk,
   output logic                                bram_porta_rst,
   output logic [BRAM_ADDR_WIDTH-1:0]          bram_porta_addr,
   output logic [BRAM_DATA_WIDTH-1:0]          bram_porta_wrdata,
   input  logic [BRAM_DATA_WIDTH-1:0]          bram_porta_rddata,
   output logic                                bram_porta_we,
   output logic                                bram_portb_clk,
   output logic                                bram_portb_rst,
   output logic [BRAM_ADDR_WIDTH-1:0]          bram_portb_addr,
   output logic [BRAM_DATA_WIDTH-1:0]          bram_portb_wrdata,
   input  logic [BRAM_DATA_WIDTH-1:0]          bram_portb_rddata,
   output logic                                bram_portb_we,
   output logic [LOG2_AVG_MAX:0]               sts_frame_cnt,
   output logic                                sts_done
);

   localparam int AW  = BRAM_ADDR_WIDTH;
   localparam int DW  = BRAM_DATA_WIDTH;
   localparam int L2W = $clog2(LOG2_AVG_MAX + 1);
   localparam int FCW = LOG2_AVG_MAX + 1;

   if (!widths_ok(AXIS_TDATA_WIDTH, BRAM_DATA_WIDTH, LOG2_AVG_MAX)) begin : g_width_check
      $error("axis_frame_averager: BRAM_DATA_WIDTH must cover AXIS_TDATA_WIDTH+LOG2_AVG_MAX");
   end

   state_t                state;
   logic [AW-1:0]         frame_len_q;
   logic [L2W-1:0]        log2_q;
   logic [AW-1:0]         idx;
   logic [AW-1:0]         rd_idx;
   logic [FCW-1:0]        frame;
   logic                  s_ready_q;
   logic                  rd_done;
   logic                  sts_done_q;

   logic                  wr_pend;
   logic                  wr_first;
   logic [AW-1:0]         wr_addr;
   logic [AXIS_TDATA_WIDTH-1:0] sample_d;
   logic                  rd_pend;
   logic                  rd_last_pend;

   logic                  s_hs;
   logic                  last_idx;
   logic                  last_frame;
   logic                  rd_last;
   logic                  rd_issue;
   logic                  done_hs;
   logic [1:0]            credit;
   logic [DW-1:0]         sample_ext;
   logic [DW-1:0]         avg_data;
   logic                  unused_portb_rddata;

   assign s_hs       = S_AXIS_tvalid & s_ready_q;
   assign last_idx   = (idx == frame_len_q);
   assign last_frame = ((frame + FCW'(1)) == (FCW'(1) << log2_q));
   assign rd_last    = (rd_idx == frame_len_q);
   // A read may only be issued when a buffer slot is guaranteed for its data next cycle.
   assign rd_issue   = (state == DRAIN) && !rd_done && (credit > {1'b0, rd_pend});
   assign done_hs    = M_AXIS_tvalid & M_AXIS_tready & M_AXIS_tlast;

   assign sample_ext = DW'(sext(WORD_MAX'(sample_d), AXIS_TDATA_WIDTH));
   assign avg_data   = DW'(asr(WORD_MAX'(bram_porta_rddata), DW, int'(log2_q)));

   assign bram_porta_clk    = aclk;
   assign bram_porta_rst    = areset;
   assign bram_porta_addr   = (state == DRAIN) ? rd_idx : idx;
   assign bram_porta_wrdata = '0;
   assign bram_porta_we     = 1'b0;

   assign bram_portb_clk    = aclk;
   assign bram_portb_rst    = areset;
   assign bram_portb_addr   = wr_addr;
   assign bram_portb_we     = wr_pend;
   assign bram_portb_wrdata = wr_first ? sample_ext : (bram_porta_rddata + sample_ext);
   assign unused_portb_rddata = ^bram_portb_rddata;

   assign S_AXIS_tready = s_ready_q;
   assign sts_done      = sts_done_q;
   assign sts_frame_cnt = frame;

   // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         state       <= IDLE;
         frame_len_q <= '0;
         log2_q      <= '0;
         idx         <= '0;
         rd_idx      <= '0;
         frame       <= '0;
         s_ready_q   <= 1'b0;
         rd_done     <= 1'b0;
         sts_done_q  <= 1'b0;
      end else begin
         sts_done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (cfg_enable) begin
                  frame_len_q <= cfg_frame_len;
                  log2_q      <= cfg_log2_avg;
                  idx         <= '0;
                  frame       <= '0;
                  s_ready_q   <= 1'b1;
                  state       <= ACCUM;
               end
            end
            ACCUM: begin
               if (s_hs) begin
                  if (!last_idx) begin
                     idx <= idx + AW'(1);
                  end else begin
                     idx <= '0;
                     if (!cfg_enable) begin
                        frame     <= '0;
                        s_ready_q <= 1'b0;
                        state     <= IDLE;
                     end else if (last_frame) begin
                        frame     <= frame + FCW'(1);
                        s_ready_q <= 1'b0;
                        rd_idx    <= '0;
                        rd_done   <= 1'b0;
                        state     <= DRAIN;
                     end else begin
                        frame <= frame + FCW'(1);
                     end
                  end
               end
            end
            DRAIN: begin
               if (rd_issue) begin
                  if (rd_last) rd_done <= 1'b1;
                  else         rd_idx  <= rd_idx + AW'(1);
               end
               if (done_hs) begin
                  sts_done_q <= 1'b1;
                  frame      <= '0;
                  idx        <= '0;
                  rd_idx     <= '0;
                  rd_done    <= 1'b0;
                  if (cfg_enable) begin
                     s_ready_q <= 1'b1;
                     state     <= ACCUM;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Read-modify-write stage: the handshake cycle reads, the following cycle writes back.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         wr_pend      <= 1'b0;
         wr_first     <= 1'b0;
         wr_addr      <= '0;
         sample_d     <= '0;
         rd_pend      <= 1'b0;
         rd_last_pend <= 1'b0;
      end else begin
         wr_pend      <= s_hs;
         rd_pend      <= rd_issue;
         rd_last_pend <= rd_issue & rd_last;
         if (s_hs) begin
            wr_addr  <= idx;
            sample_d <= S_AXIS_tdata;
            wr_first <= (frame == '0);
         end
      end
   end

   axis_averager_skid #(
      .DATA_WIDTH (DW)
   ) u_skid (
      .clk      (aclk),
      .rst      (areset),
      .in_valid (rd_pend),
      .in_data  (avg_data),
      .in_last  (rd_last_pend),
      .credit   (credit),
      .m_tdata  (M_AXIS_tdata),
      .m_tvalid (M_AXIS_tvalid),
      .m_tready (M_AXIS_tready),
      .m_tlast  (M_AXIS_tlast)
   );

endmodule

// File: tb/tb_axis_frame_averager.sv
// Self-checking bench for axis_frame_averager: directed vector table, randomized
// pass against a sum-and-shift reference model, reset and enable-drop sequences.
module tb_axis_frame_averager;

   localparam int AXW = 16;
   localparam int DW  = 32;
   localparam int AW  = 10;
   localparam int L2M = 8;

   logic                aclk = 1'b0;
   logic                areset;
   logic [AW-1:0]       cfg_frame_len;
   logic [3:0]          cfg_log2_avg;
   logic                cfg_enable;
   logic [AXW-1:0]      S_AXIS_tdata;
   logic                S_AXIS_tvalid;
   logic                S_AXIS_tready;
   logic [DW-1:0]       M_AXIS_tdata;
   logic                M_AXIS_tvalid;
   logic                M_AXIS_tready;
   logic                M_AXIS_tlast;
   logic                bram_porta_clk, bram_porta_rst, bram_porta_we;
   logic [AW-1:0]       bram_porta_addr;
   logic [DW-1:0]       bram_porta_wrdata, bram_porta_rddata;
   logic                bram_portb_clk, bram_portb_rst, bram_portb_we;
   logic [AW-1:0]       bram_portb_addr;
   logic [DW-1:0]       bram_portb_wrdata, bram_portb_rddata;
   logic [L2M:0]        sts_frame_cnt;
   logic                sts_done;

   axis_frame_averager #(
      .AXIS_TDATA_WIDTH (AXW),
      .BRAM_DATA_WIDTH  (DW),
      .BRAM_ADDR_WIDTH  (AW),
      .LOG2_AVG_MAX     (L2M)
   ) dut (
      .aclk              (aclk),
      .areset            (areset),
      .cfg_frame_len     (cfg_frame_len),
      .cfg_log2_avg      (cfg_log2_avg),
      .cfg_enable        (cfg_enable),
      .S_AXIS_tdata      (S_AXIS_tdata),
      .S_AXIS_tvalid     (S_AXIS_tvalid),
      .S_AXIS_tready     (S_AXIS_tready),
      .M_AXIS_tdata      (M_AXIS_tdata),
      .M_AXIS_tvalid     (M_AXIS_tvalid),
      .M_AXIS_tready     (M_AXIS_tready),
      .M_AXIS_tlast      (M_AXIS_tlast),
      .bram_porta_clk    (bram_porta_clk),
      .bram_porta_rst    (bram_porta_rst),
      .bram_porta_addr   (bram_porta_addr),
      .bram_porta_wrdata (bram_porta_wrdata),
      .bram_porta_rddata (bram_porta_rddata),
      .bram_porta_we     (bram_porta_we),
      .bram_portb_clk    (bram_portb_clk),
      .bram_portb_rst    (bram_portb_rst),
      .bram_portb_addr   (bram_portb_addr),
      .bram_portb_wrdata (bram_portb_wrdata),
      .bram_portb_rddata (bram_portb_rddata),
      .bram_portb_we     (bram_portb_we),
      .sts_frame_cnt     (sts_frame_cnt),
      .sts_done          (sts_done)
   );

   always #5 aclk = ~aclk;

   // Simple dual-port BRAM with one cycle of read latency; contents start as garbage.
   logic [DW-1:0] mem [0:(1<<AW)-1];
   assign bram_portb_rddata = '0;
   always @(posedge bram_portb_clk) if (bram_portb_we) mem[bram_portb_addr] <= bram_portb_wrdata;
   always @(posedge bram_porta_clk) bram_porta_rddata <= mem[bram_porta_addr];

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input longint actual, input longint expected);
      n_checks++;
      if (actual !== expected) begin
         n_errors++;
         $display("FAIL %s: actual %0d required %0d", name, actual, expected);
      end
   endtask

   typedef struct {
      int  data;
      bit  last;
   } beat_t;

   beat_t out_q[$];
   int    done_cnt   = 0;
   int    ready_mode = 0;   // 0: always ready, 1: random, 2: never ready
   bit    rand_gaps  = 1'b0;

   // Output monitor: records beats, counts done pulses, and checks stability under backpressure.
   initial begin
      bit held;
      int held_data;
      bit held_last;
      held = 1'b0;
      forever begin
         @(negedge aclk);
         if (areset) begin
            held = 1'b0;
         end else begin
            if (held) begin
               check("hold_valid", M_AXIS_tvalid, 1);
               check("hold_data", $signed(M_AXIS_tdata), held_data);
               check("hold_last", M_AXIS_tlast, held_last);
            end
            held      = M_AXIS_tvalid && !M_AXIS_tready;
            held_data = $signed(M_AXIS_tdata);
            held_last = M_AXIS_tlast;
            if (M_AXIS_tvalid && M_AXIS_tready) out_q.push_back('{$signed(M_AXIS_tdata), M_AXIS_tlast});
            if (sts_done) done_cnt++;
         end
      end
   end

   initial begin
      M_AXIS_tready = 1'b0;
      forever begin
         @(posedge aclk);
         #1;
         case (ready_mode)
            0:       M_AXIS_tready = 1'b1;
            1:       M_AXIS_tready = 1'($urandom_range(0, 1));
            default: M_AXIS_tready = 1'b0;
         endcase
      end
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic push_sample(input int d);
      int t;
      if (rand_gaps && $urandom_range(0, 3) == 0) begin
         S_AXIS_tvalid = 1'b0;
         @(posedge aclk);
         #1;
      end
      S_AXIS_tvalid = 1'b1;
      S_AXIS_tdata  = AXW'(d);
      t = 0;
      @(negedge aclk);
      while (!S_AXIS_tready && t < 1000) begin
         @(negedge aclk);
         t++;
      end
      if (!S_AXIS_tready) check("s_axis_ready_timeout", S_AXIS_tready, 1);
      @(posedge aclk);
      #1;
      S_AXIS_tvalid = 1'b0;
   endtask

   task automatic run_and_check(input int flen, input int l2, input int smp[$], input int expv[$],
                                input string name);
      int d0;
      int t;
      out_q.delete();
      d0 = done_cnt;
      cfg_frame_len = AW'(flen);
      cfg_log2_avg  = 4'(l2);
      cfg_enable    = 1'b1;
      foreach (smp[i]) push_sample(smp[i]);
      cfg_enable = 1'b0;
      t = 0;
      while (out_q.size() < expv.size() && t < 20000) begin
         @(posedge aclk);
         t++;
      end
      repeat (4) @(posedge aclk);
      #1;
      check($sformatf("%s_count", name), out_q.size(), expv.size());
      for (int i = 0; i < expv.size() && i < out_q.size(); i++) begin
         check($sformatf("%s_data%0d", name, i), out_q[i].data, expv[i]);
         check($sformatf("%s_last%0d", name, i), out_q[i].last, (i == expv.size() - 1) ? 1 : 0);
      end
      check($sformatf("%s_done_pulses", name), done_cnt - d0, 1);
      check($sformatf("%s_idle_ready", name), S_AXIS_tready, 0);
   endtask

   typedef struct {
      int flen;
      int l2;
      int smp[16];
      int expv[4];
   } vec_t;

   vec_t vecs[5];

   task automatic run_vec(input int k, input string name);
      int sq[$];
      int eq[$];
      for (int i = 0; i < ((vecs[k].flen + 1) << vecs[k].l2); i++) sq.push_back(vecs[k].smp[i]);
      for (int i = 0; i <= vecs[k].flen; i++) eq.push_back(vecs[k].expv[i]);
      run_and_check(vecs[k].flen, vecs[k].l2, sq, eq, name);
   endtask

   initial begin
      int sq[$];
      int eq[$];
      longint acc[256];
      int d;
      int t;
      int d0;

      // Frame-major samples; expected value per bin is floor(sum / 2^l2).
      vecs[0] = '{3, 2, '{1, 1, 1, 1, 2, 2, 2, 2, 3, 3, 3, 3, 4, 4, 4, 4}, '{2, 2, 2, 2}};
      vecs[1] = '{1, 0, '{-5, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0}, '{-5, 7, 0, 0}};
      vecs[2] = '{1, 1, '{-3, 5, -4, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0}, '{-4, 4, 0, 0}};
      vecs[3] = '{1, 1, '{32767, -32768, 32767, -32768, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0},
                  '{32767, -32768, 0, 0}};
      vecs[4] = '{2, 1, '{10, -10, 3, 11, -11, -4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0}, '{10, -11, -1, 0}};

      for (int i = 0; i < (1 << AW); i++) mem[i] = $urandom;

      areset        = 1'b1;
      cfg_enable    = 1'b0;
      cfg_frame_len = '0;
      cfg_log2_avg  = '0;
      S_AXIS_tvalid = 1'b0;
      S_AXIS_tdata  = '0;
      repeat (3) @(posedge aclk);
      #1;
      check("rst_s_ready", S_AXIS_tready, 0);
      check("rst_m_valid", M_AXIS_tvalid, 0);
      check("rst_m_last", M_AXIS_tlast, 0);
      check("rst_portb_we", bram_portb_we, 0);
      check("rst_done", sts_done, 0);
      check("rst_frame_cnt", sts_frame_cnt, 0);
      areset = 1'b0;
      @(posedge aclk);
      #1;

      for (int k = 0; k < 5; k++) run_vec(k, $sformatf("vec%0d", k));

      // Randomized pass with source gaps and 50% sink backpressure.
      ready_mode = 1;
      rand_gaps  = 1'b1;
      for (int i = 0; i < 256; i++) acc[i] = 0;
      for (int f = 0; f < 8; f++) begin
         for (int i = 0; i < 256; i++) begin
            d = int'($urandom_range(0, 65535)) - 32768;
            acc[i] += d;
            sq.push_back(d);
         end
      end
      for (int i = 0; i < 256; i++) eq.push_back(int'(acc[i] >>> 3));
      run_and_check(255, 3, sq, eq, "rand");

      // Reset asserted while the drain is stalled.
      ready_mode = 2;
      rand_gaps  = 1'b0;
      cfg_frame_len = AW'(3);
      cfg_log2_avg  = 4'(2);
      cfg_enable    = 1'b1;
      for (int i = 0; i < 16; i++) push_sample(vecs[0].smp[i]);
      cfg_enable = 1'b0;
      t = 0;
      while (!M_AXIS_tvalid && t < 100) begin
         @(posedge aclk);
         #1;
         t++;
      end
      repeat (3) @(posedge aclk);
      #1;
      check("stall_m_valid", M_AXIS_tvalid, 1);
      check("stall_frame_cnt", sts_frame_cnt, 4);
      #2;
      areset = 1'b1;
      #1;
      check("midrst_m_valid", M_AXIS_tvalid, 0);
      check("midrst_s_ready", S_AXIS_tready, 0);
      check("midrst_frame_cnt", sts_frame_cnt, 0);
      @(posedge aclk);
      #1;
      areset     = 1'b0;
      ready_mode = 0;
      @(posedge aclk);
      #1;
      run_vec(0, "rerun");

      // Enable dropped part-way through frame 1: frame finishes, nothing is drained.
      out_q.delete();
      d0 = done_cnt;
      cfg_frame_len = AW'(3);
      cfg_log2_avg  = 4'(2);
      cfg_enable    = 1'b1;
      for (int i = 0; i < 4; i++) push_sample(100);
      for (int i = 0; i < 2; i++) push_sample(50);
      cfg_enable = 1'b0;
      for (int i = 0; i < 2; i++) push_sample(50);
      repeat (3) @(posedge aclk);
      #1;
      check("abort_s_ready", S_AXIS_tready, 0);
      check("abort_frame_cnt", sts_frame_cnt, 0);
      repeat (20) @(posedge aclk);
      #1;
      check("abort_no_output", out_q.size(), 0);
      check("abort_no_done", done_cnt - d0, 0);
      run_vec(0, "restart");

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
